sync_fifo_param: RTL

Parametrised synchronous FIFO with configurable data width and depth. It adds simultaneous read/write, occupancy count, programmable almost-full/almost-empty flags, a read-valid strobe, and optional sticky overflow/underflow error flags. It is the general-purpose single-clock buffer between producer and consumer blocks and replaces the fixed 8-bit, 16-entry FIFO.

---
 rtl/sync_fifo_param.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds and a one-cycle read-valid strobe.
// Optional feature macro: SYNC_FIFO_ERR_EN enables the sticky
// overflow/underflow flags; without it both flags read 0 and err_clr is unused.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic                         re,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         err_clr,
  output logic [DATA_W-1:0]            data_out,
  output logic                         rd_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int ADDR_W = $clog2(DEPTH);

  // Thresholds sized to the count register so the flag decodes compare
  // equal-width operands.
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_AF   = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0]   CNT_AE   = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rd_valid_q, rd_valid_d;

  logic rd_ok;
  logic wr_ok;

  // Status flags are pure decodes of the registered count.
  always_comb begin
    full         = (count_q == CNT_FULL);
    empty        = (count_q == '0);
    almost_full  = (count_q >= CNT_AF);
    almost_empty = (count_q <= CNT_AE);
  end

  // Accept logic: a read frees a slot so a full FIFO can still take a write
  // in the same cycle; an empty FIFO never accepts a read.
  always_comb begin
    rd_ok = re & ~empty;
    wr_ok = we & (~full | rd_ok);
  end

  // Next-state for pointers, occupancy and the registered read port.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_ok) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem[rd_ptr_q];
      rd_valid_d = 1'b1;
    end
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CNT_ONE;
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Control and read-port registers; contents are discarded on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage array is intentionally left unreset; only accepted writes land.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags: a new error in the same cycle as err_clr wins.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (we & ~wr_ok) begin
      overflow_d = 1'b1;
    end
    if (re & ~rd_ok) begin
      underflow_d = 1'b1;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule
